// File: rtl/raisin64_pkg.sv
// Shared fetch-stage types: parcel/fetch widths, instruction length headers, aligner FSM states.
package raisin64_pkg;

    localparam int unsigned PARCEL_W = 16;
    localparam int unsigned FETCH_W  = 64;

    // Header bits [63:62] of the window; LEN16 covers both 2'b00 and 2'b01.
    localparam logic [1:0] LEN16 = 2'b00;
    localparam logic [1:0] LEN32 = 2'b10;
    localparam logic [1:0] LEN64 = 2'b11;

    typedef enum logic [1:0] {
        FA_IDLE = 2'd0,
        FA_WAIT = 2'd1,
        FA_DROP = 2'd2
    } fa_state_e;

endpackage

// File: rtl/fa_len_decode.sv
// Instruction header to parcel count: 0x -> 1, 10 -> 2, 11 -> 4.
module fa_len_decode
    import raisin64_pkg::*;
(
    input  logic [1:0] hdr,
    output logic [3:0] len
);

    always_comb begin
        len = 4'd1;
        if (hdr == LEN64) begin
            len = 4'd4;
        end else if (hdr == LEN32) begin
            len = 4'd2;
        end
    end

endmodule

// File: rtl/fetch_align.sv
// Fetch/align stage: fetches 64-bit words into an 8-parcel buffer and presents a left-justified
// window to decode. Optional length checker (len_err) enabled by FETCH_ALIGN_CHECK_EN.
module fetch_align
    import raisin64_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               mem_req,
    output logic [FETCH_W-1:0] mem_addr,
    input  logic               mem_ack,
    input  logic [FETCH_W-1:0] mem_rdata,
    input  logic               redirect,
    input  logic [63:0]        redirect_pc,
    output logic [FETCH_W-1:0] inst_out,
    output logic               inst_valid,
    output logic [63:0]        inst_pc,
    input  logic               stall,
    input  logic               advance16,
    input  logic               advance32,
    input  logic               advance64
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic               len_err
`endif
);

    localparam int unsigned BufW = 2 * FETCH_W;

    fa_state_e         state_q, state_d;
    logic [BufW-1:0]   buf_q, buf_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        skip_q, skip_d;
    logic [63:0]       fpc_q, fpc_d;
    logic [63:0]       pc_q, pc_d;
    logic [63:0]       req_addr_q, req_addr_d;

    logic [3:0]        head_len;
    logic [3:0]        adv_len;
    logic [3:0]        retire_len;
    logic [3:0]        retire;
    logic [3:0]        app_pos;
    logic              consume;
    logic [BufW-1:0]   shifted;
    logic [BufW-1:0]   app_word;

    fa_len_decode u_len_decode (
        .hdr (buf_q[BufW-1 -: 2]),
        .len (head_len)
    );

    assign adv_len = advance64 ? 4'd4 : advance32 ? 4'd2 : advance16 ? 4'd1 : 4'd0;

`ifdef FETCH_ALIGN_CHECK_EN
    logic err_q, err_d;

    // The header wins; a bad advance is only reported.
    assign retire_len = head_len;
    assign err_d      = consume & (($countones({advance16, advance32, advance64}) != 1) |
                                   (adv_len != head_len));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign len_err = err_q;
`else
    assign retire_len = adv_len;
`endif

    assign inst_valid = (cnt_q >= head_len);
    assign inst_out   = buf_q[BufW-1 -: FETCH_W];
    assign inst_pc    = pc_q;
    assign mem_req    = (state_q != FA_IDLE);
    assign mem_addr   = mem_req ? req_addr_q : '0;

    always_comb begin
        consume  = inst_valid & ~stall & ~redirect;
        retire   = consume ? retire_len : 4'd0;
        shifted  = buf_q << (PARCEL_W * retire);
        // Incoming parcels land right after whatever survives this cycle's retire.
        app_pos  = cnt_q - retire;
        app_word = ({mem_rdata, {FETCH_W{1'b0}}} << (PARCEL_W * skip_q)) >> (PARCEL_W * app_pos);

        state_d    = state_q;
        buf_d      = shifted;
        cnt_d      = cnt_q - retire;
        skip_d     = skip_q;
        fpc_d      = fpc_q;
        pc_d       = pc_q + {59'b0, retire, 1'b0};
        req_addr_d = req_addr_q;

        unique case (state_q)
            FA_IDLE: begin
                if (cnt_d <= 4'd4) begin
                    state_d    = FA_WAIT;
                    req_addr_d = fpc_q;
                end
            end
            FA_WAIT: begin
                if (mem_ack) begin
                    buf_d   = shifted | app_word;
                    cnt_d   = cnt_d + (4'd4 - {2'b00, skip_q});
                    skip_d  = 2'd0;
                    fpc_d   = fpc_q + 64'd8;
                    state_d = FA_IDLE;
                end
            end
            FA_DROP: begin
                if (mem_ack) begin
                    state_d = FA_IDLE;
                end
            end
            default: state_d = FA_IDLE;
        endcase

        if (redirect) begin
            buf_d  = '0;
            cnt_d  = 4'd0;
            pc_d   = redirect_pc;
            fpc_d  = {redirect_pc[63:3], 3'b000};
            skip_d = redirect_pc[2:1];
            unique case (state_q)
                FA_IDLE: begin
                    state_d    = FA_WAIT;
                    req_addr_d = {redirect_pc[63:3], 3'b000};
                end
                // An in-flight request cannot be withdrawn; swallow its data.
                FA_WAIT, FA_DROP: state_d = mem_ack ? FA_IDLE : FA_DROP;
                default: state_d = FA_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FA_IDLE;
            buf_q      <= '0;
            cnt_q      <= 4'd0;
            skip_q     <= RESET_PC[2:1];
            fpc_q      <= {RESET_PC[63:3], 3'b000};
            pc_q       <= {RESET_PC[63:1], 1'b0};
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            skip_q     <= skip_d;
            fpc_q      <= fpc_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: parcel-queue reference model, behavioural memory, directed + random tests.
module tb_fetch_align;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [63:0] inst_out;
    logic        inst_valid;
    logic [63:0] inst_pc;
    logic        stall;
    logic        advance16, advance32, advance64;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        len_err;
`endif

    fetch_align dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_out    (inst_out),
        .inst_valid  (inst_valid),
        .inst_pc     (inst_pc),
        .stall       (stall),
        .advance16   (advance16),
        .advance32   (advance32),
        .advance64   (advance64)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .len_err     (len_err)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: fetched parcels as a plain queue in program order.
    logic [15:0] q[$];
    logic [63:0] m_pc, m_fpc;
    int          m_skip;
    bit          m_stale;
    bit          m_err;
    int          mode, lat, wait_cnt, cyc, first_valid;
    bit          auto_adv;
    int          cons_len[$];
    logic [63:0] cons_pc[$];

    function automatic int hlen(input logic [15:0] p);
        if (!p[15]) return 1;
        if (!p[14]) return 2;
        return 4;
    endfunction

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [31:0] h;
        h = a[34:3];
        case (mode)
            0: return a[3] ? 64'hC005_0006_0007_0008 : 64'h0001_0002_8003_0004;
            2: return 64'h1111_C222_0333_0444;
            default: return {(h * 32'h9E37_79B1) ^ 32'h1234_5678, (h ^ 32'h5BD1_E995) * 32'h85EB_CA6B};
        endcase
    endfunction

    function automatic bit m_valid();
        return (q.size() != 0) && (q.size() >= hlen(q[0]));
    endfunction

    function automatic logic [63:0] m_window();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) if (i < q.size()) w[63-16*i -: 16] = q[i];
        return w;
    endfunction

    // One clock: drive advance, compare, step model, clock, then memory response at negedge.
    task automatic cycle();
        logic [63:0] exp_win;
        logic [63:0] w;
        bit          exp_v;
        int          n;
        exp_v   = m_valid();
        exp_win = m_window();
        if (auto_adv) begin
            advance16 = 1'b0; advance32 = 1'b0; advance64 = 1'b0;
            if (exp_v) begin
                n = hlen(q[0]);
                advance16 = (n == 1); advance32 = (n == 2); advance64 = (n == 4);
            end
        end
        #1;
        tests++;
        if (inst_valid !== exp_v) begin
            fails++; $display("FAIL inst_valid cyc=%0d got %b want %b", cyc, inst_valid, exp_v);
        end
        tests++;
        if (inst_out !== exp_win) begin
            fails++; $display("FAIL inst_out cyc=%0d got %h want %h", cyc, inst_out, exp_win);
        end
        tests++;
        if (inst_pc !== m_pc) begin
            fails++; $display("FAIL inst_pc cyc=%0d got %h want %h", cyc, inst_pc, m_pc);
        end
`ifdef FETCH_ALIGN_CHECK_EN
        tests++;
        if (len_err !== m_err) begin
            fails++; $display("FAIL len_err cyc=%0d got %b want %b", cyc, len_err, m_err);
        end
`endif
        if (first_valid < 0 && inst_valid === 1'b1) first_valid = cyc;
        m_err = 1'b0;
        if (redirect) begin
            q.delete();
            m_pc   = redirect_pc;
            m_fpc  = {redirect_pc[63:3], 3'b000};
            m_skip = int'(redirect_pc[2:1]);
            if (mem_ack) m_stale = 1'b0;
            else if (mem_req) m_stale = 1'b1;
        end else begin
            if (exp_v && !stall) begin
                n = hlen(q[0]);
`ifdef FETCH_ALIGN_CHECK_EN
                m_err = ($countones({advance16, advance32, advance64}) != 1) ||
                        ((advance64 ? 4 : advance32 ? 2 : advance16 ? 1 : 0) != n);
`endif
                cons_len.push_back(n);
                cons_pc.push_back(m_pc);
                repeat (n) void'(q.pop_front());
                m_pc += 64'(2 * n);
            end
            if (mem_ack) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    tests++;
                    if (mem_addr !== m_fpc) begin
                        fails++; $display("FAIL mem_addr cyc=%0d got %h want %h", cyc, mem_addr, m_fpc);
                    end
                    tests++;
                    if (q.size() + 4 - m_skip > 8) begin
                        fails++; $display("FAIL overflow cyc=%0d got %0d parcels want <=8",
                                          cyc, q.size() + 4 - m_skip);
                    end
                    w = mem_word(m_fpc);
                    for (int i = m_skip; i < 4; i++) q.push_back(w[63-16*i -: 16]);
                    m_fpc += 64'd8;
                    m_skip = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (mem_ack) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
            tests++;
            if (mem_req !== 1'b0) begin
                fails++; $display("FAIL req_after_ack cyc=%0d got %b want 0", cyc, mem_req);
            end
        end else if (mem_req) begin
            if (wait_cnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                wait_cnt  = 0;
                lat       = (mode == 1) ? int'($urandom_range(1, 3)) : 1;
            end else begin
                wait_cnt++;
            end
        end
        if (!mem_ack) mem_rdata = {$urandom(), $urandom()};
        cyc++;
    endtask

    task automatic do_reset(input int md);
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        advance16 = 1'b0; advance32 = 1'b0; advance64 = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        mode = md; lat = 1; wait_cnt = 0; auto_adv = 1'b1;
        q.delete(); m_pc = '0; m_fpc = '0; m_skip = 0; m_stale = 1'b0; m_err = 1'b0;
        cyc = 0; first_valid = -1; cons_len.delete(); cons_pc.delete();
        @(negedge clk);
        #1;
        tests++;
        if ({mem_req, mem_addr, inst_valid, inst_out, inst_pc} !== '0) begin
            fails++; $display("FAIL reset_outputs got req=%b addr=%h v=%b out=%h pc=%h want all 0",
                              mem_req, mem_addr, inst_valid, inst_out, inst_pc);
        end
`ifdef FETCH_ALIGN_CHECK_EN
        tests++;
        if (len_err !== 1'b0) begin
            fails++; $display("FAIL reset_len_err got %b want 0", len_err);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1);
        repeat (4) cycle();
    endtask

    task automatic test_basic();
        int exp_len[5] = '{1, 1, 2, 4, 1};
        int exp_pc[5]  = '{0, 2, 4, 8, 16};
        do_reset(0);
        repeat (30) cycle();
        tests++;
        if (first_valid != 3) begin
            fails++; $display("FAIL first_valid got %0d want 3", first_valid);
        end
        tests++;
        if (cons_len.size() < 5) begin
            fails++; $display("FAIL retire_count got %0d want >=5", cons_len.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (cons_len[i] != exp_len[i] || cons_pc[i] !== 64'(exp_pc[i])) begin
                    fails++; $display("FAIL retire%0d got len=%0d pc=%h want len=%0d pc=%0h",
                                      i, cons_len[i], cons_pc[i], exp_len[i], exp_pc[i]);
                end
            end
        end
    endtask

    task automatic test_redirect_drop();
        logic [63:0] old_addr, w;
        int k;
        do_reset(1);
        k = 0;
        while (!(mem_req === 1'b1 && mem_ack === 1'b0) && k < 20) begin cycle(); k++; end
        old_addr    = mem_addr;
        redirect    = 1'b1;
        redirect_pc = 64'h106;
        cycle();
        redirect = 1'b0;
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== old_addr) begin
            fails++; $display("FAIL drop_hold got req=%b addr=%h want 1 %h", mem_req, mem_addr, old_addr);
        end
        k = 0;
        while (q.size() == 0 && k < 30) begin cycle(); k++; end
        w = mem_word(64'h100);
        tests++;
        if (inst_pc !== 64'h106 || inst_out !== {w[15:0], 48'h0}) begin
            fails++; $display("FAIL redirect_refill got pc=%h out=%h want 106 %h",
                              inst_pc, inst_out, {w[15:0], 48'h0});
        end
        repeat (20) cycle();
    endtask

    task automatic test_stall_full();
        logic [63:0] win;
        int k;
        do_reset(1);
        stall = 1'b1;
        k = 0;
        while (q.size() != 8 && k < 40) begin cycle(); k++; end
        tests++;
        if (q.size() != 8) begin
            fails++; $display("FAIL stall_fill got %0d parcels want 8", q.size());
        end
        win = inst_out;
        for (int i = 0; i < 10; i++) begin
            cycle();
            tests++;
            if (mem_req !== 1'b0 || inst_out !== win) begin
                fails++; $display("FAIL stall_hold got req=%b out=%h want 0 %h", mem_req, inst_out, win);
            end
        end
        stall = 1'b0;
        repeat (40) cycle();
    endtask

    task automatic test_partial_long();
        int k;
        do_reset(2);
        redirect = 1'b1;
        redirect_pc = 64'h202;
        cycle();
        redirect = 1'b0;
        k = 0;
        while (q.size() != 3 && k < 20) begin cycle(); k++; end
        tests++;
        if (inst_valid !== 1'b0 || inst_out !== 64'hC222_0333_0444_0000) begin
            fails++; $display("FAIL partial64 got v=%b out=%h want 0 c222033304440000", inst_valid, inst_out);
        end
        k = 0;
        while (q.size() == 3 && k < 20) begin cycle(); k++; end
        tests++;
        if (inst_valid !== 1'b1) begin
            fails++; $display("FAIL partial64_fill got v=%b want 1", inst_valid);
        end
        repeat (10) cycle();
    endtask

    task automatic test_redirect_ack();
        logic [63:0] rpc;
        int k;
        do_reset(1);
        k = 0;
        while (!(mem_ack === 1'b1 && m_valid()) && k < 200) begin cycle(); k++; end
        tests++;
        if (!(mem_ack === 1'b1 && m_valid())) begin
            fails++; $display("FAIL redir_ack_setup got ack=%b want ack with valid head", mem_ack);
        end
        rpc = 64'h2000 + 64'(2 * $urandom_range(0, 15));
        redirect = 1'b1;
        redirect_pc = rpc;
        cycle();
        redirect = 1'b0;
        tests++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== rpc || inst_out !== 64'h0) begin
            fails++; $display("FAIL redir_ack got req=%b v=%b pc=%h out=%h want 0 0 %h 0",
                              mem_req, inst_valid, inst_pc, inst_out, rpc);
        end
        repeat (20) cycle();
    endtask

    task automatic test_random();
        do_reset(1);
        redirect = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFA;
        cycle();
        redirect = 1'b0;
        for (int i = 0; i < 600; i++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = {$urandom(), $urandom()} & ~64'h1;
            cycle();
        end
        redirect = 1'b0;
        stall = 1'b0;
        repeat (10) cycle();
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_len_err();
        int k;
        do_reset(0);
        auto_adv = 1'b0;
        stall = 1'b1;
        k = 0;
        while (!m_valid() && k < 20) begin cycle(); k++; end
        stall = 1'b0;
        advance32 = 1'b1;
        cycle();
        advance32 = 1'b0;
        stall = 1'b1;
        tests++;
        if (len_err !== 1'b1 || inst_pc !== 64'h2) begin
            fails++; $display("FAIL len_err_pulse got err=%b pc=%h want 1 2", len_err, inst_pc);
        end
        cycle();
        tests++;
        if (len_err !== 1'b0) begin
            fails++; $display("FAIL len_err_clear got %b want 0", len_err);
        end
        auto_adv = 1'b1;
        stall = 1'b0;
        repeat (10) cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_redirect_drop();
        test_stall_full();
        test_partial_long();
        test_redirect_ack();
`ifdef FETCH_ALIGN_CHECK_EN
        test_len_err();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
